seg7_msg_scroller: RTL and testbench
====================================

Name: seg7_msg_scroller

Overview:
- Sequential successor to the combinational 7-segment letter decoder.
- Steps through a stored message of up to 16 glyphs on one 7-segment digit at a programmable rate, inserting a blank gap between characters so repeated letters stay distinguishable.
- Supports run/pause, single-step, reverse direction and a runtime message length.
- Sits between the project top and the segment output pins.

Parameters:
- CLK_DIV, 10000000: clock cycles per tick (1 s at 10 MHz); minimum 1.
- SHOW_TICKS, 3: ticks each glyph is shown; minimum 1.
- GAP_TICKS, 1: blank ticks after each glyph; 0 disables the gap.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = auto-advance on ticks, 0 = paused
- step  in  1  manual advance; rising edge acts only while run=0
- dir  in  1  0 = forward (index+1), 1 = reverse (index-1)
- msg_len  in  4  active message length minus 1 (0..15 → 1..16 glyphs)
- segments  out  7  segment drive, bit0 = seg1 … bit6 = seg7 (middle), active-high
- dp  out  1  decimal point
- char_idx  out  4  current message index
- wrap  out  1  one-cycle pulse when the index wraps

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, tick counter = 0, state = SHOW, char_idx = 0.
  - segments = 0, dp = 0, wrap = 0, step edge register = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while run=1; `tick` is asserted in the cycle it equals CLK_DIV-1, then it returns to 0.
  - While run=0 it holds its value; it does not clear.
- FSM states SHOW and GAP, with a phase counter cleared on every state change:
  - SHOW: on tick, phase increments. At phase = SHOW_TICKS-1, go to GAP (or advance the index and stay in SHOW if GAP_TICKS=0).
  - GAP: on tick at phase = GAP_TICKS-1, advance the index and go to SHOW.
- Advance:
  - Forward: the index after msg_len is 0.
  - Reverse: the index after 0 is msg_len.
  - wrap pulses for one cycle, coincident with the index update, whenever the index wraps.
  - If msg_len is lowered below char_idx, the next advance goes to 0 (forward) or msg_len (reverse) and pulses wrap.
- Step:
  - The registered rising-edge of step while run=0 performs an advance immediately, from either state. It enters SHOW with phase 0 and does not touch the prescaler.
  - A step edge while run=1 is ignored.
  - Holding step high gives exactly one advance.
- Output:
  - segments is registered and is one cycle behind the state/index.
  - SHOW: segments = glyph(ROM[char_idx]).
  - GAP: segments = 0.
- ROM:
  - Indices 0..6 hold R, O, G, E, L, I, O. These are the segment codes 0x70, 0x3F, 0x6F, 0x79, 0x38, 0x30, 0x3F as 7654321 bit strings.
  - Indices 7..15 hold BLANK.
- Glyph codes: 5-bit, covering BLANK, digits 0-9, and letters A C E F G H I L O P R U. An unknown code decodes to 0.

Optional Feature:
- SEG7_SCROLL_DP_EN
  - Defined: dp = 1 while in SHOW at char_idx = msg_len (last glyph marker), registered together with segments.
  - Undefined: dp is tied to 0 and no related logic is built.

Decomposition:
- Package seg7_scroll_pkg holds:
  - the glyph-code typedef (5-bit enum) and code constants;
  - the state enum {SHOW, GAP};
  - the default message ROM constant array.
- Sub-module seg7_glyph: combinational glyph code → 7-bit segment pattern, instantiated once on the ROM output.

Test Plan:
- Reset: CLK_DIV=4, SHOW_TICKS=2, GAP_TICKS=1, run=1, msg_len=6; assert rst_n=0 mid-run → segments=0, char_idx=0 and wrap=0 immediately. After release, the first advance occurs 12 cycles later.
- Forward sequence: same parameters → segments show 0x70 for 8 cycles, then 0 for 4 cycles, then 0x3F, and so on. After index 6 comes 0 with a one-cycle wrap pulse; the full period is 84 cycles.
- Reverse: dir=1 from char_idx=0 → next index 6 (0x3F) with wrap=1, then 5 (0x30).
- Pause and step: run=0 holds segments indefinitely. Each rising edge of step advances exactly one index; step held high 20 cycles → one advance. step with run=1 → no change.
- Length change: char_idx=5, set msg_len=2 → next advance goes to 0 with wrap. With msg_len=0, every advance stays at 0 and pulses wrap.
- DP feature: SEG7_SCROLL_DP_EN defined, msg_len=6 → dp=1 only while showing index 6, 0 during GAP. Undefined → dp is always 0.

Source files
------------

// File: rtl/seg7_scroll_pkg.sv
// Shared types for the 7-segment message scroller: glyph codes, FSM states
// and the default message ROM.
package seg7_scroll_pkg;

    typedef enum logic [4:0] {
        GL_BLANK = 5'd0,
        GL_0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
        GL_A, GL_C, GL_E, GL_F, GL_G, GL_H, GL_I, GL_L, GL_O, GL_P,
        GL_R, GL_U
    } glyph_t;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam int unsigned MSG_DEPTH = 16;

    localparam glyph_t MSG_ROM [MSG_DEPTH] = '{
        GL_R, GL_O, GL_G, GL_E, GL_L, GL_I, GL_O,
        GL_BLANK, GL_BLANK, GL_BLANK, GL_BLANK, GL_BLANK,
        GL_BLANK, GL_BLANK, GL_BLANK, GL_BLANK
    };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph-code to 7-segment decoder; bit0 = seg1 (a) ... bit6 = seg7 (g).
// Codes outside the glyph set decode to all segments off.
module seg7_glyph
    import seg7_scroll_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        case (code)
            GL_BLANK: seg = 7'h00;
            GL_0:     seg = 7'h3F;
            GL_1:     seg = 7'h06;
            GL_2:     seg = 7'h5B;
            GL_3:     seg = 7'h4F;
            GL_4:     seg = 7'h66;
            GL_5:     seg = 7'h6D;
            GL_6:     seg = 7'h7D;
            GL_7:     seg = 7'h07;
            GL_8:     seg = 7'h7F;
            GL_9:     seg = 7'h6F;
            GL_A:     seg = 7'h77;
            GL_C:     seg = 7'h39;
            GL_E:     seg = 7'h79;
            GL_F:     seg = 7'h71;
            GL_G:     seg = 7'h6F;
            GL_H:     seg = 7'h76;
            GL_I:     seg = 7'h30;
            GL_L:     seg = 7'h38;
            GL_O:     seg = 7'h3F;
            GL_P:     seg = 7'h73;
            GL_R:     seg = 7'h70;
            GL_U:     seg = 7'h3E;
            default:  seg = '0;
        endcase
    end

endmodule

// File: rtl/seg7_msg_scroller.sv
// Scrolls the stored message across one 7-segment digit with a blank gap per glyph.
// Optional last-glyph decimal point marker: define SEG7_SCROLL_DP_EN.
module seg7_msg_scroller
    import seg7_scroll_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 10000000,
    parameter int unsigned SHOW_TICKS = 3,
    parameter int unsigned GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       dir,
    input  logic [3:0] msg_len,
    output logic [6:0] segments,
    output logic       dp,
    output logic [3:0] char_idx,
    output logic       wrap
);

    localparam int unsigned PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PH_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PHW-1:0] SHOW_LAST = PHW'(SHOW_TICKS - 1);
    localparam logic [PHW-1:0] GAP_LAST  = PHW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit             GAP_EN    = (GAP_TICKS > 0);

    logic [PW-1:0]  presc;
    logic           tick;
    logic           step_q;
    logic           step_adv;
    state_t         state, state_n;
    logic [PHW-1:0] phase, phase_n;
    logic           adv;
    logic [3:0]     adv_idx;
    logic           adv_wrap;
    logic [3:0]     idx_n;
    logic           wrap_n;
    glyph_t         rom_code;
    logic [6:0]     rom_seg;
    logic [6:0]     seg_n;

    assign tick     = run && (presc == PRE_LAST);
    assign step_adv = step && !step_q && !run;

    // Prescaler freezes (does not clear) while paused so resuming keeps cadence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= step;
            if (run) begin
                presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
            end
        end
    end

    // Out-of-range index (msg_len lowered) wraps like a normal end-of-message.
    always_comb begin
        adv_idx  = '0;
        adv_wrap = 1'b0;
        if (!dir) begin
            if (char_idx >= msg_len) begin
                adv_idx  = '0;
                adv_wrap = 1'b1;
            end else begin
                adv_idx  = char_idx + 1'b1;
            end
        end else begin
            if ((char_idx == '0) || (char_idx > msg_len)) begin
                adv_idx  = msg_len;
                adv_wrap = 1'b1;
            end else begin
                adv_idx  = char_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW;
            phase    <= '0;
            char_idx <= '0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            char_idx <= idx_n;
            wrap     <= wrap_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        adv     = 1'b0;
        if (step_adv) begin
            adv     = 1'b1;
            state_n = SHOW;
            phase_n = '0;
        end else if (tick) begin
            case (state)
                SHOW: begin
                    if (phase == SHOW_LAST) begin
                        phase_n = '0;
                        if (GAP_EN) begin
                            state_n = GAP;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                GAP: begin
                    if (phase == GAP_LAST) begin
                        adv     = 1'b1;
                        state_n = SHOW;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                default: begin
                    state_n = SHOW;
                    phase_n = '0;
                end
            endcase
        end
        idx_n  = adv ? adv_idx : char_idx;
        wrap_n = adv & adv_wrap;
    end

    assign rom_code = MSG_ROM[char_idx];

    seg7_glyph u_glyph (
        .code (rom_code),
        .seg  (rom_seg)
    );

    always_comb begin
        seg_n = (state == SHOW) ? rom_seg : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments <= '0;
        end else begin
            segments <= seg_n;
        end
    end

`ifdef SEG7_SCROLL_DP_EN
    logic dp_n;

    always_comb begin
        dp_n = (state == SHOW) && (char_idx == msg_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= 1'b0;
        end else begin
            dp <= dp_n;
        end
    end
`else
    assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Scoreboard bench for seg7_msg_scroller (CLK_DIV=4, SHOW_TICKS=2, GAP_TICKS=1).
// Expected advances are queued as stimulus is driven and popped when the index moves or wrap pulses.
module tb_seg7_msg_scroller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       dir;
    logic [3:0] msg_len;
    logic [6:0] segments;
    logic       dp;
    logic [3:0] char_idx;
    logic       wrap;

    seg7_msg_scroller #(
        .CLK_DIV    (4),
        .SHOW_TICKS (2),
        .GAP_TICKS  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .dir      (dir),
        .msg_len  (msg_len),
        .segments (segments),
        .dp       (dp),
        .char_idx (char_idx),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       wrp;
        int         gap;
        bit         auto_m;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit         mon_en   = 1'b0;
    bit         seg_pend = 1'b0;
    bit         gap_chk  = 1'b0;
    logic [3:0] pend_idx = '0;
    logic [3:0] last_idx = '0;
    int         last_chg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] rom_seg(input logic [3:0] i);
        case (i)
            4'd0:    return 7'h70;
            4'd1:    return 7'h3F;
            4'd2:    return 7'h6F;
            4'd3:    return 7'h79;
            4'd4:    return 7'h38;
            4'd5:    return 7'h30;
            4'd6:    return 7'h3F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic exp_dp(input logic [3:0] i, input logic [3:0] len);
`ifdef SEG7_SCROLL_DP_EN
        return (i == len);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic [3:0] i, input logic w, input int g, input bit a);
        exp_t e;
        e.idx = i;
        e.wrp = w;
        e.gap = g;
        e.auto_m = a;
        sb.push_back(e);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: segment check one cycle after each advance, gap blanking mid-period.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (seg_pend) begin
                check("seg_show", {24'd0, dp, segments}, {24'd0, exp_dp(pend_idx, msg_len), rom_seg(pend_idx)});
                seg_pend = 1'b0;
            end
            if (gap_chk && run && (cyc - last_chg == 10))
                check("seg_gap", {24'd0, dp, segments}, 32'd0);
            if ((char_idx !== last_idx) || wrap) begin
                if (sb.size() == 0) begin
                    check("unexpected_adv", {27'd0, wrap, char_idx}, {27'd0, 1'b0, last_idx});
                end else begin
                    mon_e = sb.pop_front();
                    check("idx", {28'd0, char_idx}, {28'd0, mon_e.idx});
                    check("wrap", {31'd0, wrap}, {31'd0, mon_e.wrp});
                    if (mon_e.gap != 0)
                        check("adv_period", cyc - last_chg, mon_e.gap);
                    gap_chk  = mon_e.auto_m;
                    seg_pend = 1'b1;
                    pend_idx = mon_e.idx;
                end
                last_idx = char_idx;
                last_chg = cyc;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        run     = 1'b1;
        step    = 1'b0;
        dir     = 1'b0;
        msg_len = 4'd6;
        repeat (3) @(negedge clk);
        check("rst_seg",  {25'd0, segments}, 32'd0);
        check("rst_idx",  {28'd0, char_idx}, 32'd0);
        check("rst_wrap", {31'd0, wrap},     32'd0);
        check("rst_dp",   {31'd0, dp},       32'd0);

        // First advance 12 cycles after release, then async reset mid-run.
        push(4'd1, 1'b0, 12, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; last_idx = '0; last_chg = cyc; seg_pend = 1'b0; gap_chk = 1'b0; mon_en = 1'b1;
        repeat (20) @(negedge clk);
        drain(10);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_seg",  {25'd0, segments}, 32'd0);
        check("midrst_idx",  {28'd0, char_idx}, 32'd0);
        check("midrst_wrap", {31'd0, wrap},     32'd0);
        repeat (2) @(negedge clk);

        // Full forward period: 7 glyphs x 12 cycles, wrap back to 0.
        for (int i = 1; i <= 6; i++) push(4'(i), 1'b0, 12, 1'b1);
        push(4'd0, 1'b1, 12, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; last_idx = '0; last_chg = cyc; seg_pend = 1'b0; gap_chk = 1'b0; mon_en = 1'b1;
        drain(200);

        // Reverse from index 0.
        dir = 1'b1;
        push(4'd6, 1'b1, 12, 1'b1);
        push(4'd5, 1'b0, 12, 1'b1);
        push(4'd4, 1'b0, 12, 1'b1);
        drain(200);

        // Pause holds index and display.
        run = 1'b0;
        repeat (30) @(negedge clk);
        check("pause_idx", {28'd0, char_idx}, 32'd4);
        check("pause_seg", {25'd0, segments}, 32'h38);

        dir = 1'b0;
        push(4'd5, 1'b0, 0, 1'b0);
        step_pulse();
        drain(10);

        push(4'd6, 1'b0, 0, 1'b0);
        @(negedge clk);
        step = 1'b1;
        repeat (20) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        drain(10);

        // Step edge while running is ignored.
        run  = 1'b1;
        step = 1'b1;
        repeat (3) @(negedge clk);
        check("step_run_idx", {28'd0, char_idx}, 32'd6);
        run  = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);

        // Length changes.
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        for (int i = 1; i <= 5; i++) begin
            push(4'(i), 1'b0, 0, 1'b0);
            step_pulse();
        end
        drain(10);
        msg_len = 4'd2;
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        msg_len = 4'd0;
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        dir = 1'b1;
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        drain(10);

        dir = 1'b0;
        msg_len = 4'd6;
        for (int i = 1; i <= 5; i++) begin
            push(4'(i), 1'b0, 0, 1'b0);
            step_pulse();
        end
        msg_len = 4'd2;
        dir = 1'b1;
        push(4'd2, 1'b1, 0, 1'b0);
        step_pulse();
        push(4'd1, 1'b0, 0, 1'b0);
        step_pulse();
        dir = 1'b0;
        push(4'd2, 1'b0, 0, 1'b0);
        step_pulse();
        push(4'd0, 1'b1, 0, 1'b0);
        step_pulse();
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
